// File: rtl/selfcomp_leak_monitor.sv
// selfcomp_leak_monitor
//   Watches N_CH self-composed copies of a design that all accepted the same
//   input transaction (start). It measures how long the first copy takes to
//   answer (latency) and how far apart the copies finish (skew). Any skew, or
//   a copy that never answers, is flagged as a timing leak. Results that
//   differ between copies are flagged as a result mismatch.
//
// Ports
//   clock            sole clock, rising edge
//   reset            asynchronous, active-low
//   start            transaction accepted by all copies (honoured in IDLE only)
//   clear            zeroes sticky flags and leak_count (a same-cycle set wins)
//   ch_valid         per-copy out_valid
//   ch_result        per-copy result, copy i at [i*DATA_W +: DATA_W]
//   out_ready        common ready to the copies (high while waiting)
//   init             one-cycle pulse on the first edge after reset release
//   busy             FSM not in IDLE
//   any_valid        OR of ch_valid
//   all_valid        AND of ch_valid
//   timing_leak      sticky, copies completed in different cycles
//   result_mismatch  sticky, copies produced different results
//   timed_out        sticky, a transaction was abandoned
//   timing_leak_done one-cycle pulse when a transaction concludes
//   latency          start to first valid, last transaction
//   skew             first valid to last valid, last transaction
//   leak_count       leaking transactions, saturating
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_FIRST | counting latency until any copy answers
// WAIT_ALL   | counting skew until every copy has answered
// DONE       | one-cycle wrap-up, updates leak flag and count
module selfcomp_leak_monitor #(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*DATA_W-1:0] ch_result,
  output logic                   out_ready,
  output logic                   init,
  output logic                   busy,
  output logic                   any_valid,
  output logic                   all_valid,
  output logic                   timing_leak,
  output logic                   result_mismatch,
  output logic                   timed_out,
  output logic                   timing_leak_done,
  output logic [CNT_W-1:0]       latency,
  output logic [CNT_W-1:0]       skew,
  output logic [15:0]            leak_count
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_ALL, DONE} state_e;

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q;
  logic [CNT_W-1:0]  lat_q;
  logic [CNT_W-1:0]  skew_cnt_q;
  logic [CNT_W-1:0]  latency_q;
  logic [CNT_W-1:0]  skew_q;
  logic [N_CH-1:0]   seen_q;
  logic [DATA_W-1:0] ref_q;
  logic              started_q;
  logic              init_q;
  logic              busy_q;
  logic              ready_q;
  logic              done_q;
  logic              leak_pend_q;
  logic              leak_q;
  logic              mism_q;
  logic              to_q;
  logic [15:0]       leak_cnt_q;

  logic [CNT_W-1:0]  lat_inc;
  logic [CNT_W-1:0]  skew_inc;
  logic [N_CH-1:0]   seen_d;
  logic [N_CH-1:0]   new_valid;
  logic [DATA_W-1:0] first_res;
  logic              mism_first;
  logic              mism_new;
  logic [15:0]       leak_cnt_d;

  always_comb begin
    lat_inc   = (lat_q == CNT_MAX) ? lat_q : lat_q + CNT_W'(1);
    skew_inc  = (skew_cnt_q == CNT_MAX) ? skew_cnt_q : skew_cnt_q + CNT_W'(1);
    seen_d    = seen_q | ch_valid;
    new_valid = ch_valid & ~seen_q;

    // reference result comes from the lowest-index copy answering first
    first_res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_valid[i]) first_res = ch_result[i*DATA_W +: DATA_W];
    end

    mism_first = 1'b0;
    mism_new   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid[i] && (ch_result[i*DATA_W +: DATA_W] != first_res)) mism_first = 1'b1;
      if (new_valid[i] && (ch_result[i*DATA_W +: DATA_W] != ref_q)) mism_new = 1'b1;
    end

    // a clear in the same cycle as a leak restarts the count at one
    if (clear) leak_cnt_d = 16'd1;
    else if (leak_cnt_q == 16'hFFFF) leak_cnt_d = leak_cnt_q;
    else leak_cnt_d = leak_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      skew_cnt_q  <= '0;
      latency_q   <= '0;
      skew_q      <= '0;
      seen_q      <= '0;
      ref_q       <= '0;
      started_q   <= 1'b0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      leak_pend_q <= 1'b0;
      leak_q      <= 1'b0;
      mism_q      <= 1'b0;
      to_q        <= 1'b0;
      leak_cnt_q  <= '0;
    end else begin
      started_q <= 1'b1;
      init_q    <= ~started_q;
      done_q    <= 1'b0;

      // set conditions below are written later and therefore win over clear
      if (clear) begin
        leak_q     <= 1'b0;
        mism_q     <= 1'b0;
        to_q       <= 1'b0;
        leak_cnt_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT_FIRST;
            lat_q   <= '0;
            seen_q  <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end

        WAIT_FIRST: begin
          lat_q <= lat_inc;
          if (|ch_valid) begin
            latency_q <= lat_inc;
            seen_q    <= ch_valid;
            ref_q     <= first_res;
            if (mism_first) mism_q <= 1'b1;
            if (&ch_valid) begin
              state_q     <= DONE;
              skew_q      <= '0;
              leak_pend_q <= 1'b0;
              ready_q     <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q    <= WAIT_ALL;
              skew_cnt_q <= CNT_W'(1);
            end
          end else if (lat_inc == TO_CNT) begin
            // nobody answered: abandoned, but not a leak
            state_q     <= DONE;
            to_q        <= 1'b1;
            latency_q   <= lat_inc;
            skew_q      <= '0;
            leak_pend_q <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b1;
          end
        end

        WAIT_ALL: begin
          seen_q <= seen_d;
          if (mism_new) mism_q <= 1'b1;
          if (&seen_d) begin
            state_q     <= DONE;
            skew_q      <= skew_cnt_q;
            leak_pend_q <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b1;
          end else if (skew_cnt_q == TO_CNT) begin
            // some copies answered and others never did: a leak
            state_q     <= DONE;
            to_q        <= 1'b1;
            skew_q      <= skew_cnt_q;
            leak_pend_q <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            skew_cnt_q <= skew_inc;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (leak_pend_q) begin
            leak_q     <= 1'b1;
            leak_cnt_q <= leak_cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_ready        = ready_q;
  assign init             = init_q;
  assign busy             = busy_q;
  assign any_valid        = |ch_valid;
  assign all_valid        = &ch_valid;
  assign timing_leak      = leak_q;
  assign result_mismatch  = mism_q;
  assign timed_out        = to_q;
  assign timing_leak_done = done_q;
  assign latency          = latency_q;
  assign skew             = skew_q;
  assign leak_count       = leak_cnt_q;

endmodule

// File: doc/selfcomp_leak_monitor.md
SELFCOMP_LEAK_MONITOR -- requirements
Module: selfcomp_leak_monitor

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_CH, 2, number of self-composed DUT copies observed (legal range 2..8).
- DATA_W, 128, width of each copy's result.
- CNT_W, 8, width of the latency and skew counters.
- TIMEOUT, 255, wait cycles before a transaction is abandoned (must fit in CNT_W).
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-low; 0 = in reset.
- start, in, 1, pulse marking the input transaction accepted by all copies.
- clear, in, 1, clears the sticky flags and leak_count.
- ch_valid, in, N_CH, per-copy out_valid.
- ch_result, in, N_CH*DATA_W, per-copy result; copy i occupies bits [i*DATA_W +: DATA_W].
- out_ready, out, 1, common ready to all copies.
- init, out, 1, high for exactly one cycle after reset deasserts.
- busy, out, 1, FSM not in IDLE.
- any_valid, out, 1, OR of ch_valid (combinational).
- all_valid, out, 1, AND of ch_valid (combinational).
- timing_leak, out, 1, sticky: copies completed in different cycles.
- result_mismatch, out, 1, sticky: copies produced different results.
- timed_out, out, 1, sticky: a transaction hit TIMEOUT.
- timing_leak_done, out, 1, one-cycle pulse when a transaction concludes.
- latency, out, CNT_W, cycles from start to first valid, last transaction.
- skew, out, CNT_W, cycles from first to last valid, last transaction.
- leak_count, out, 16, transactions that leaked, saturating.

Function
REQ-004 FSM states: IDLE, WAIT_FIRST, WAIT_ALL, DONE.
REQ-005 IDLE: start=1 -> WAIT_FIRST; internal lat counter and seen mask load 0.
REQ-006 start outside IDLE is ignored.
REQ-007 out_ready=1 only in WAIT_FIRST and WAIT_ALL; valid&out_ready is a completed handshake for that copy.
REQ-008 WAIT_FIRST: lat counter increments each cycle and saturates at all-ones.
REQ-009 WAIT_FIRST, on first cycle with any ch_valid: latency <= lat counter; seen <= ch_valid; ref <= result of lowest-index valid copy.
REQ-010 Same cycle as REQ-009: all ch_valid set -> DONE with skew=0; otherwise -> WAIT_ALL with skew counter=1.
REQ-011 WAIT_ALL: seen |= ch_valid each cycle; skew counter increments per cycle while seen is incomplete.
REQ-012 WAIT_ALL: seen becomes all-ones -> DONE; skew <= cycles from first valid to last valid.
REQ-013 A repeat valid from an already-seen copy is ignored.
REQ-014 Result compare: each copy's result at its first handshake is compared with ref; any inequality sets result_mismatch, including among copies valid in the same cycle.
REQ-015 Timeout: wait counter reaches TIMEOUT in WAIT_FIRST or WAIT_ALL -> DONE and timed_out set.
REQ-016 Timeout in WAIT_ALL also counts as a leak; timeout in WAIT_FIRST (no copy responded) does not.
REQ-017 DONE lasts one cycle: timing_leak_done=1; if skew!=0 or WAIT_ALL timeout, timing_leak set and leak_count incremented (saturating at 0xFFFF); then -> IDLE.
REQ-018 clear=1 zeroes timing_leak, result_mismatch, timed_out and leak_count; a set condition in the same cycle overrides clear.
REQ-019 clear does not change FSM state, latency or skew.

Reset
REQ-020 While reset=0: FSM=IDLE; counters, seen, ref, latency, skew, leak_count=0; all flags=0; out_ready=0; timing_leak_done=0; init=0.
REQ-021 init=1 on the first clock edge after reset rises and 0 thereafter.
REQ-022 Reset asserted mid-transaction aborts immediately: no timing_leak_done pulse, and no flag or count update.

Verification
REQ-023 N_CH=2, start; both copies valid 3 cycles later with equal results -> latency=3, skew=0, timing_leak=0, timing_leak_done pulses once.
REQ-024 N_CH=4, start; copies 0,1 valid at cycle 2, copy 3 at cycle 4, copy 2 at cycle 6 -> skew=4, timing_leak=1, leak_count=1.
REQ-025 Copies simultaneously valid with copy 1 result = copy 0 result XOR 1 -> result_mismatch=1, timing_leak=0.
REQ-026 TIMEOUT=8, only copy 0 responds -> DONE 8 cycles after its valid, timed_out=1, timing_leak=1; with no copy responding -> timed_out=1, timing_leak=0.
REQ-027 Reset pulsed low during WAIT_ALL -> all outputs 0, busy=0, init=1 for one cycle after release; a subsequent clean transaction reports skew=0.
REQ-028 leak_count preloaded to 0xFFFF by forced leaks, then one more leak -> leak_count stays 0xFFFF; clear in the same cycle as a DONE leak -> timing_leak=1 and leak_count=1.
